// File: rtl/swan_pkg.sv
// Shared SWAN64 constants and types for the serial rho datapath.
package swan_pkg;

   localparam int BLOCK_SIZE    = 64;
   localparam int SIDE_SIZE     = BLOCK_SIZE / 2;
   localparam int COLUMN_SIZE   = SIDE_SIZE / 4;
   localparam int COLS_PER_SIDE = 4;
   localparam int CNT_W         = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      EMIT = 2'd2
   } rho_state_t;

   // True when the column index addresses the final column of a half-state.
   function automatic logic is_last_col(input logic [CNT_W-1:0] idx);
      return (idx == CNT_W'(COLS_PER_SIDE - 1));
   endfunction

endpackage

// File: rtl/swan_col_buf.sv
// Four-entry column register file: one write port, one combinational read port.
module swan_col_buf
   import swan_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [CNT_W-1:0]       wr_idx,
   input  logic [COLUMN_SIZE-1:0] wr_data,
   input  logic [CNT_W-1:0]       rd_idx,
   output logic [COLUMN_SIZE-1:0] rd_data
);

   logic [COLUMN_SIZE-1:0] mem_q [COLS_PER_SIDE];
   logic [COLUMN_SIZE-1:0] mem_d [COLS_PER_SIDE];

   // Next-state of the register file: single write port.
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_idx] = wr_data;
      end else begin
         mem_d = mem_q;
      end
   end

   // Storage registers, cleared on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < COLS_PER_SIDE; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/serial_rho_inv_stream.sv
// Column-serial inverse of the SWAN64 rho layer: gathers four columns,
// then emits y[i] = a[i] ^ (a[0]^a[1]^a[2]^a[3]) one column per handshake.
module serial_rho_inv_stream
   import swan_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [COLUMN_SIZE-1:0] in_col,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [COLUMN_SIZE-1:0] out_col,
   output logic                   out_last,
   output logic                   busy
);

   rho_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [COLUMN_SIZE-1:0] s_q, s_d;
   logic                   rst_done_q, rst_done_d;

   logic                   buf_wr_en_s;
   logic [CNT_W-1:0]       buf_wr_idx_s;
   logic [COLUMN_SIZE-1:0] buf_wr_data_s;
   logic [COLUMN_SIZE-1:0] buf_rd_data_s;
   logic                   in_hs_s;
   logic                   out_hs_s;

   swan_col_buf u_col_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (buf_wr_en_s),
      .wr_idx  (buf_wr_idx_s),
      .wr_data (buf_wr_data_s),
      .rd_idx  (cnt_q),
      .rd_data (buf_rd_data_s)
   );

   // Outputs depend only on registers; in_ready stays low until the first edge after reset.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_col   = '0;
      out_last  = 1'b0;
      busy      = (state_q != IDLE);
      if (state_q == EMIT) begin
         out_valid = 1'b1;
         out_col   = buf_rd_data_s ^ s_q;
         out_last  = is_last_col(cnt_q);
      end else begin
         in_ready  = rst_done_q;
      end
   end

   assign in_hs_s  = in_valid && in_ready;
   assign out_hs_s = out_valid && out_ready;

   // Next-state logic: clr beats any handshake in the same cycle.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      s_d           = s_q;
      rst_done_d    = 1'b1;
      buf_wr_en_s   = 1'b0;
      buf_wr_idx_s  = cnt_q;
      buf_wr_data_s = in_col;
      if (clr) begin
         state_d = IDLE;
         cnt_d   = '0;
         s_d     = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_hs_s) begin
                  buf_wr_en_s  = 1'b1;
                  buf_wr_idx_s = '0;
                  s_d          = in_col;
                  cnt_d        = CNT_W'(1);
                  state_d      = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
            LOAD: begin
               if (in_hs_s) begin
                  buf_wr_en_s = 1'b1;
                  s_d         = s_q ^ in_col;
                  cnt_d       = cnt_q + CNT_W'(1);
                  if (is_last_col(cnt_q)) begin
                     state_d = EMIT;
                  end else begin
                     state_d = LOAD;
                  end
               end else begin
                  state_d = LOAD;
               end
            end
            EMIT: begin
               if (out_hs_s) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (is_last_col(cnt_q)) begin
                     state_d = IDLE;
                     s_d     = '0;
                  end else begin
                     state_d = EMIT;
                  end
               end else begin
                  state_d = EMIT;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               s_d     = '0;
            end
         endcase
      end
   end

   // State, column index, accumulator and reset-release registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         s_q        <= '0;
         rst_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         s_q        <= s_d;
         rst_done_q <= rst_done_d;
      end
   end

endmodule

// File: tb/tb_serial_rho_inv_stream.sv
// Self-checking bench: parallel rho reference model with directed and random traffic.
module tb_serial_rho_inv_stream;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_col = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_col;
   logic       out_last;
   logic       busy;

   int checks = 0;
   int failures = 0;

   logic [7:0] part[$];
   logic [8:0] exp_q[$];
   logic [8:0] got[$];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_col = 8'h00;

   serial_rho_inv_stream dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_col    (in_col),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_col   (out_col),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Parallel rho on a 32-bit half-state, column a[0] in the top byte.
   function automatic logic [31:0] rho32(input logic [31:0] h);
      logic [7:0] s;
      s = h[31:24] ^ h[23:16] ^ h[15:8] ^ h[7:0];
      return h ^ {4{s}};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model and per-cycle output comparison.
   always @(negedge clk) begin
      if (!rst_n || clr) begin
         part.delete();
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (out_valid) begin
            checks++;
            if (in_ready) begin
               failures++;
               $display("FAIL overlap: in_ready=%b while out_valid=1", in_ready);
            end
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_out: got %h expected none", {out_last, out_col});
            end else if ({out_last, out_col} !== exp_q[0]) begin
               failures++;
               $display("FAIL stream: got last=%b col=%h expected last=%b col=%h",
                        out_last, out_col, exp_q[0][8], exp_q[0][7:0]);
            end
            if (prev_stall) begin
               checks++;
               if (out_col !== prev_col) begin
                  failures++;
                  $display("FAIL hold: got %h expected %h", out_col, prev_col);
               end
            end
            if (out_ready) begin
               got.push_back({out_last, out_col});
               if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            prev_stall = !out_ready;
            prev_col   = out_col;
         end else begin
            prev_stall = 1'b0;
         end
         if (in_valid && in_ready) begin
            part.push_back(in_col);
            if (part.size() == 4) begin
               logic [31:0] y;
               y = rho32({part[0], part[1], part[2], part[3]});
               for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), y[31-8*i -: 8]});
               part.delete();
            end
         end
      end
   end

   task automatic send_cols(input logic [7:0] a [4]);
      for (int i = 0; i < 4; i++) begin
         int n;
         in_valid = 1'b1;
         in_col   = a[i];
         n = 0;
         while (!in_ready && n < 100) begin
            tick();
            n++;
         end
         if (n >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic expect4(input string nm, input logic [7:0] e [4]);
      int n;
      n = 0;
      while (got.size() < 4 && n < 100) begin
         tick();
         n++;
      end
      chk({nm, "_count"}, 32'(got.size()), 32'd4);
      if (got.size() >= 4) begin
         for (int i = 0; i < 4; i++) chk(nm, 32'(got[i]), 32'({(i == 3), e[i]}));
      end
      got.delete();
   endtask

   initial begin
      logic [7:0] g [4];

      // Model pins: parallel rho on hand-computed vectors.
      chk("model_basis", rho32(32'h01020408), 32'h0E0D0B07);
      chk("model_invol", rho32(32'h0E0D0B07), 32'h01020408);
      chk("model_ff",    rho32(32'h000000FF), 32'hFFFFFF00);

      #3;
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_col",   32'(out_col),   32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;

      g = '{8'h01, 8'h02, 8'h04, 8'h08};
      send_cols(g);
      chk("latency_y0_valid", 32'(out_valid), 32'd1);
      chk("latency_y0_col",   32'(out_col),   32'h0E);
      expect4("basis", '{8'h0E, 8'h0D, 8'h0B, 8'h07});

      send_cols('{8'h0E, 8'h0D, 8'h0B, 8'h07});
      expect4("involution", '{8'h01, 8'h02, 8'h04, 8'h08});
      send_cols('{8'hA5, 8'hA5, 8'hA5, 8'hA5});
      expect4("equal_a5", '{8'hA5, 8'hA5, 8'hA5, 8'hA5});
      send_cols('{8'h00, 8'h00, 8'h00, 8'hFF});
      expect4("zero_ff", '{8'hFF, 8'hFF, 8'hFF, 8'h00});

      // Backpressure at y[1].
      send_cols(g);
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_col",       32'(out_col),   32'h0D);
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      expect4("backpressure", '{8'h0E, 8'h0D, 8'h0B, 8'h07});

      // clr after two inputs, coincident with a third handshake.
      in_valid = 1'b1; in_col = 8'h55; tick();
      in_col = 8'h66; tick();
      in_col = 8'h77; clr = 1'b1; tick();
      clr = 1'b0; in_valid = 1'b0;
      chk("clr_busy",     32'(busy),     32'd0);
      chk("clr_in_ready", 32'(in_ready), 32'd1);
      send_cols(g);
      expect4("after_clr", '{8'h0E, 8'h0D, 8'h0B, 8'h07});

      // Async reset while emitting.
      out_ready = 1'b0;
      send_cols('{8'h11, 8'h22, 8'h33, 8'h44});
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_busy",      32'(busy),      32'd0);
      chk("midrst_in_ready",  32'(in_ready),  32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      chk("rel_out_valid", 32'(out_valid), 32'd0);
      got.delete();
      out_ready = 1'b1;
      send_cols(g);
      expect4("after_rst", '{8'h0E, 8'h0D, 8'h0B, 8'h07});

      // Random traffic with valid gaps, backpressure and rare flushes.
      for (int c = 0; c < 40000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_col    = 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         clr       = ($urandom_range(0, 999) == 0);
         tick();
      end
      clr = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) tick();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      chk("final_busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
